// File: rtl/mem_io_ctrl_pkg.sv
// Shared definitions for the memory/IO controller: FSM encoding, widths and
// default register addresses.
package mem_io_ctrl_pkg;

    localparam int ADDR_W     = 9;
    localparam int RAM_ADDR_W = 8;
    localparam int DATA_W     = 16;
    localparam int SW_W       = 10;

    localparam logic [ADDR_W-1:0] LED_ADDR_DEF = 9'h100;
    localparam logic [ADDR_W-1:0] SW_ADDR_DEF  = 9'h140;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // IO space (addr[8]=1) holds only the LED and switch registers.
    function automatic logic is_unmapped(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] led_addr,
                                         input logic [ADDR_W-1:0] sw_addr);
        return addr[ADDR_W-1] && (addr != led_addr) && (addr != sw_addr);
    endfunction

endpackage

// File: rtl/mem_io_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous board switches.
module sync2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// CPU-side controller routing single accesses to a synchronous RAM, the LED
// register or the synchronized switch register; reads complete in fixed time.
module mem_io_ctrl
    import mem_io_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LED_ADDR = LED_ADDR_DEF,
    parameter logic [ADDR_W-1:0] SW_ADDR  = SW_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_rvalid,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  bus_err,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    input  logic [SW_W-1:0]       sw,
    output logic [SW_W-1:0]       ledr
);

    state_t            state;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [SW_W-1:0]   req_led;
    logic [SW_W-1:0]   sw_sync;
    logic [DATA_W-1:0] rd_mux;

    sync2 #(.W(SW_W)) u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_sync)
    );

    assign cpu_ready = (state == IDLE);

    // Evaluated in RESP, when the RAM has had one cycle to return data.
    always_comb begin
        rd_mux = '0;
        if (!req_addr[ADDR_W-1])
            rd_mux = ram_rdata;
        else if (req_addr == LED_ADDR)
            rd_mux = {{(DATA_W-SW_W){1'b0}}, ledr};
        else if (req_addr == SW_ADDR)
            rd_mux = {{(DATA_W-SW_W){1'b0}}, sw_sync};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_led    <= '0;
            ledr       <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            bus_err    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            ram_we     <= 1'b0;
            bus_err    <= 1'b0;
            cpu_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_we   <= cpu_we;
                        req_addr <= cpu_addr;
                        req_led  <= cpu_wdata[SW_W-1:0];
                        // RAM-side and error outputs are registered here so
                        // they are valid during the ACCESS cycle itself.
                        if (!cpu_addr[ADDR_W-1]) begin
                            ram_addr  <= cpu_addr[RAM_ADDR_W-1:0];
                            ram_wdata <= cpu_wdata;
                            ram_we    <= cpu_we;
                        end
                        bus_err <= is_unmapped(cpu_addr, LED_ADDR, SW_ADDR);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (req_we) begin
                        if (req_addr == LED_ADDR)
                            ledr <= req_led;
                        state <= IDLE;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    cpu_rdata  <= rd_mux;
                    cpu_rvalid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl with a behavioural synchronous RAM.
module tb_mem_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [8:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        bus_err;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [9:0]  sw;
    logic [9:0]  ledr;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    logic [15:0] exp_q[$];
    int          exp_rv_cyc_q[$];
    int          exp_err_cyc_q[$];
    logic [23:0] exp_we_q[$];
    int          exp_we_cyc_q[$];

    logic [15:0] ram_mem [256];

    mem_io_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .bus_err    (bus_err),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .sw         (sw),
        .ledr       (ledr)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;
        ram_rdata = 16'h0000;
    end

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // driver: waits for ready, presents one request for the accept edge
    task automatic issue(input logic we, input logic [8:0] addr, input logic [15:0] wdata,
                         input logic track, input logic [15:0] exp_rdata, input logic exp_err);
        int n = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        while (!cpu_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_ready) check("ready_timeout", 32'd0, 32'd1);
        if (track) begin
            if (!we) begin
                exp_q.push_back(exp_rdata);
                exp_rv_cyc_q.push_back(cyc + 3);
            end
            if (exp_err) exp_err_cyc_q.push_back(cyc + 1);
            if (we && !addr[8]) begin
                exp_we_q.push_back({addr[7:0], wdata});
                exp_we_cyc_q.push_back(cyc + 1);
            end
        end
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    // monitor: compares every DUT output event against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_rvalid) begin
                if (exp_q.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    check("rdata", {16'h0, cpu_rdata}, {16'h0, exp_q.pop_front()});
                    check("rvalid_cycle", cyc, exp_rv_cyc_q.pop_front());
                end
            end
            if (bus_err) begin
                if (exp_err_cyc_q.size() == 0) check("unexpected_bus_err", 32'd1, 32'd0);
                else check("bus_err_cycle", cyc, exp_err_cyc_q.pop_front());
            end
            if (ram_we) begin
                if (exp_we_q.size() == 0) check("unexpected_ram_we", 32'd1, 32'd0);
                else begin
                    check("ram_we_addr_data", {8'h0, ram_addr, ram_wdata}, {8'h0, exp_we_q.pop_front()});
                    check("ram_we_cycle", cyc, exp_we_cyc_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; sw = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'h0, cpu_ready}, 32'd1);
        check("rst_rvalid", {31'h0, cpu_rvalid}, 32'd0);
        check("rst_ledr", {22'h0, ledr}, 32'd0);
        check("rst_rdata", {16'h0, cpu_rdata}, 32'd0);
        check("rst_ram_we", {31'h0, ram_we}, 32'd0);
        check("rst_ram_addr", {24'h0, ram_addr}, 32'd0);

        // RAM write then read back
        issue(1'b1, 9'h012, 16'hBEEF, 1'b1, 16'h0000, 1'b0);
        issue(1'b0, 9'h012, 16'h0000, 1'b1, 16'hBEEF, 1'b0);

        // LED register write/read
        issue(1'b1, 9'h100, 16'hFFFF, 1'b1, 16'h0000, 1'b0);
        @(negedge clk); @(negedge clk);
        check("ledr_after_write", {22'h0, ledr}, 32'h3FF);
        issue(1'b0, 9'h100, 16'h0000, 1'b1, 16'h03FF, 1'b0);

        // switches through the synchronizer
        @(negedge clk);
        sw = 10'h2A5;
        repeat (3) @(negedge clk);
        issue(1'b0, 9'h140, 16'h0000, 1'b1, 16'h02A5, 1'b0);

        // unmapped read and write, then a write to the read-only switch register
        issue(1'b0, 9'h1FF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        issue(1'b1, 9'h1FF, 16'h0123, 1'b1, 16'h0000, 1'b1);
        @(negedge clk); @(negedge clk);
        check("ledr_after_unmapped_wr", {22'h0, ledr}, 32'h3FF);
        issue(1'b1, 9'h140, 16'h0000, 1'b1, 16'h0000, 1'b0);
        @(negedge clk); @(negedge clk);
        check("ledr_after_sw_wr", {22'h0, ledr}, 32'h3FF);

        // top RAM address
        issue(1'b1, 9'h0FF, 16'h1234, 1'b1, 16'h0000, 1'b0);
        issue(1'b0, 9'h0FF, 16'h0000, 1'b1, 16'h1234, 1'b0);

        // cpu_req held high: only IDLE accepts, one response per 3 cycles
        @(negedge clk);
        n = 0;
        while (!cpu_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_ready", {31'h0, cpu_ready}, 32'd1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h012;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(16'hBEEF);
            exp_rv_cyc_q.push_back(cyc + 3 + 3 * k);
        end
        repeat (9) @(posedge clk);
        #1 cpu_req = 1'b0;

        // reset right after a read is accepted aborts it
        issue(1'b0, 9'h012, 16'h0000, 1'b0, 16'h0000, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {31'h0, cpu_ready}, 32'd1);
        check("post_reset_ledr", {22'h0, ledr}, 32'd0);
        check("post_reset_rdata", {16'h0, cpu_rdata}, 32'd0);

        repeat (10) @(negedge clk);
        check("rvalid_q_drained", exp_q.size(), 32'd0);
        check("err_q_drained", exp_err_cyc_q.size(), 32'd0);
        check("we_q_drained", exp_we_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
